// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - op and state types shared by the iterative multiply/divide unit
package HighLevelControl;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mulDivOp;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mulDivState;

  function automatic logic op_is_div(mulDivOp op);
    return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
  endfunction

  function automatic logic op_is_quot(mulDivOp op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // MUL only needs the low half, which is sign-agnostic, so it runs unsigned
  function automatic logic op_a_signed(mulDivOp op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_b_signed(mulDivOp op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/mul_div_sign_fix.sv
// rtl/mul_div_sign_fix.sv - conditional two's complement (abs value on entry, sign restore on exit)
module mul_div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(WIDTH-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M/RV64M multiply/divide, one result bit per cycle
module mul_div_unit
  import HighLevelControl::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Flush,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("mul_div_unit: WIDTH must be 32 or 64");
  end

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mulDivState         r_state;
  mulDivOp            r_op;
  logic [WIDTH-1:0]   r_a;       // operand A, then |A|, then quotient for divides
  logic [WIDTH-1:0]   r_b;       // operand B, then |B|; shifted right as multiplier
  logic [2*WIDTH:0]   r_acc;     // product with carry; low WIDTH+1 bits are the remainder
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;

  logic               w_sa_in;
  logic               w_sb_in;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_b_zero;
  logic               w_ovf;
  logic               w_special;
  logic [WIDTH-1:0]   w_special_res;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH+1:0]   w_diff;
  logic               w_fits;
  logic [WIDTH:0]     w_rem_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_res;

  assign w_sa_in = op_a_signed(r_op) & r_a[WIDTH-1];
  assign w_sb_in = op_b_signed(r_op) & r_b[WIDTH-1];

  mul_div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.i_val(r_a), .i_neg(w_sa_in), .o_val(w_abs_a));
  mul_div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.i_val(r_b), .i_neg(w_sb_in), .o_val(w_abs_b));

  // Divide-by-zero and signed overflow are resolved without iterating
  assign w_b_zero      = (r_b == {WIDTH{1'b0}});
  assign w_ovf         = ((r_op == DIV) || (r_op == REM)) &&
                         (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == {WIDTH{1'b1}});
  assign w_special     = op_is_div(r_op) && (w_b_zero || w_ovf);
  assign w_special_res = op_is_quot(r_op) ? (w_b_zero ? {WIDTH{1'b1}} : r_a)
                                          : (w_b_zero ? r_a : {WIDTH{1'b0}});

  // Shift-add step: add multiplicand into the high half, then shift the whole product right
  assign w_addend  = r_b[0] ? r_a : {WIDTH{1'b0}};
  assign w_mul_sum = r_acc[2*WIDTH:WIDTH] + {1'b0, w_addend};

  // Restoring step: shift next dividend bit into the remainder, subtract if it fits
  assign w_trial    = {r_acc[WIDTH-1:0], r_a[WIDTH-1]};
  assign w_diff     = {1'b0, w_trial} - {2'b00, r_b};
  assign w_fits     = ~w_diff[WIDTH+1];
  assign w_rem_next = w_fits ? w_diff[WIDTH:0] : w_trial;

  mul_div_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .i_val(r_acc[2*WIDTH-1:0]), .i_neg(r_sign_a ^ r_sign_b), .o_val(w_prod));
  mul_div_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
    .i_val(r_a), .i_neg(r_sign_a ^ r_sign_b), .o_val(w_quot));
  mul_div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .i_val(r_acc[WIDTH-1:0]), .i_neg(r_sign_a), .o_val(w_rem));

  // Pick the architectural result out of the sign-corrected datapath
  always_comb begin
    w_fix_res = w_prod[WIDTH-1:0];
    case (r_op)
      MUL:                 w_fix_res = w_prod[WIDTH-1:0];
      MULH, MULHSU, MULHU: w_fix_res = w_prod[2*WIDTH-1:WIDTH];
      DIV, DIVU:           w_fix_res = w_quot;
      REM, REMU:           w_fix_res = w_rem;
      default:             w_fix_res = w_prod[WIDTH-1:0];
    endcase
  end

  // Control FSM with registered Busy/Done/Result and the iterating datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_op     <= MUL;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start && !Flush) begin
            r_op    <= mulDivOp'(Op);
            r_a     <= OpA;
            r_b     <= OpB;
            r_state <= PREP;
            r_busy  <= 1'b1;
          end
        end
        PREP: begin
          if (Flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_special) begin
            r_result <= w_special_res;
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_a      <= w_abs_a;
            r_b      <= w_abs_b;
            r_sign_a <= w_sa_in;
            r_sign_b <= w_sb_in;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= ITER;
          end
        end
        ITER: begin
          if (Flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (op_is_div(r_op)) begin
              r_acc <= {{WIDTH{1'b0}}, w_rem_next};
              r_a   <= {r_a[WIDTH-2:0], w_fits};
            end else begin
              r_acc <= {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};
              r_b   <= {1'b0, r_b[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST) begin
              r_state <= FIX;
            end
          end
        end
        FIX: begin
          if (Flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_result <= w_fix_res;
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy   = r_busy;
  assign Done   = r_done;
  assign Result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized self-checking bench for mul_div_unit (WIDTH 32 and 64)
module tb_mul_div_unit;
  import HighLevelControl::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst   [2];
  logic        start [2];
  logic        flush [2];
  logic [2:0]  opc   [2];
  logic [63:0] opa   [2];
  logic [63:0] opb   [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] res0;
  logic [63:0] res1;

  mul_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst[0]), .Start(start[0]), .Flush(flush[0]), .Op(opc[0]),
    .OpA(opa[0][31:0]), .OpB(opb[0][31:0]), .Busy(busy[0]), .Done(done[0]), .Result(res0));

  mul_div_unit #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(rst[1]), .Start(start[1]), .Flush(flush[1]), .Op(opc[1]),
    .OpA(opa[1]), .OpB(opb[1]), .Busy(busy[1]), .Done(done[1]), .Result(res1));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] wmask(int w);
    return (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] wmin(int w);
    return (w == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
  endfunction

  // Reference result straight from the RISC-V M-extension definitions using wide arithmetic
  function automatic logic [63:0] model(int w, logic [2:0] op, logic [63:0] a, logic [63:0] b);
    logic signed [129:0] sa, sb, ua, ub, p;
    logic [63:0] am, bm, r;
    am = a & wmask(w);
    bm = b & wmask(w);
    if (w == 32) begin
      sa = $signed(am[31:0]);
      sb = $signed(bm[31:0]);
    end else begin
      sa = $signed(am);
      sb = $signed(bm);
    end
    ua = {66'b0, am};
    ub = {66'b0, bm};
    case (op)
      3'd0: begin p = sa * sb; r = p[63:0]; end
      3'd1: begin p = (sa * sb) >>> w; r = p[63:0]; end
      3'd2: begin p = (sa * ub) >>> w; r = p[63:0]; end
      3'd3: begin p = (ua * ub) >>> w; r = p[63:0]; end
      3'd4: begin
        if (bm == 0) r = '1;
        else if (am == wmin(w) && bm == wmask(w)) r = am;
        else begin p = sa / sb; r = p[63:0]; end
      end
      3'd5: begin
        if (bm == 0) r = '1;
        else begin p = ua / ub; r = p[63:0]; end
      end
      3'd6: begin
        if (bm == 0) r = am;
        else if (am == wmin(w) && bm == wmask(w)) r = '0;
        else begin p = sa % sb; r = p[63:0]; end
      end
      default: begin
        if (bm == 0) r = am;
        else begin p = ua % ub; r = p[63:0]; end
      end
    endcase
    return r & wmask(w);
  endfunction

  function automatic bit is_special(int w, logic [2:0] op, logic [63:0] a, logic [63:0] b);
    logic [63:0] am, bm;
    am = a & wmask(w);
    bm = b & wmask(w);
    if (op < 3'd4) return 1'b0;
    if (bm == 0) return 1'b1;
    return ((op == 3'd4) || (op == 3'd6)) && (am == wmin(w)) && (bm == wmask(w));
  endfunction

  function automatic logic [63:0] rnd(int w);
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = wmask(w);
      2: v = wmin(w);
      3: v = 64'($urandom_range(0, 20));
      default: ;
    endcase
    return v & wmask(w);
  endfunction

  // Expected timeline per DUT: busy window, done cycle, committed and held result
  logic        m_active  [2];
  int          m_start   [2];
  int          m_done    [2];
  int          m_busy_to [2];
  int          m_rst     [2];
  logic [63:0] m_res     [2];
  logic [63:0] m_held    [2];
  bit          cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin : per_dut
        logic        ed, eb;
        logic [63:0] got;
        if (cyc == m_rst[d] + 1) m_held[d] = '0;
        ed = m_active[d] && (cyc == m_done[d]);
        eb = m_active[d] && (cyc > m_start[d]) && (cyc <= m_busy_to[d]);
        if (ed) m_held[d] = m_res[d];
        got = (d == 0) ? {32'b0, res0} : res1;
        chk(d ? "Done64" : "Done32", {63'b0, done[d]}, {63'b0, ed});
        chk(d ? "Busy64" : "Busy32", {63'b0, busy[d]}, {63'b0, eb});
        chk(d ? "Result64" : "Result32", got, m_held[d]);
        if (m_active[d] && cyc >= m_busy_to[d] && cyc >= m_done[d]) m_active[d] = 1'b0;
      end
    end
  end

  // kind: 0 none, 1 flush, 2 reset, 3 stray Start while busy; rel = cycles after Start
  task automatic issue(int d, logic [2:0] op, logic [63:0] a, logic [63:0] b,
                       int kind, int rel, bit has_lit, logic [63:0] lit, string nm);
    int w, c, lat;
    logic [63:0] got;
    w   = d ? 64 : 32;
    c   = cyc;
    lat = is_special(w, op, a, b) ? 2 : w + 3;
    start[d] = 1'b1;
    opc[d]   = op;
    opa[d]   = a;
    opb[d]   = b;
    m_start[d]   = c;
    m_done[d]    = c + lat;
    m_busy_to[d] = c + lat - 1;
    m_res[d]     = model(w, op, a, b);
    m_active[d]  = 1'b1;
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk);
      #1;
      start[d] = 1'b0;
      flush[d] = 1'b0;
      rst[d]   = 1'b0;
      opa[d]   = {$urandom, $urandom};
      opb[d]   = {$urandom, $urandom};
      opc[d]   = 3'($urandom);
      if (kind != 0 && k == rel) begin
        case (kind)
          1: begin
            flush[d] = 1'b1;
            if (c + k < m_done[d]) begin
              m_busy_to[d] = c + k;
              m_done[d]    = -1;
            end
          end
          2: begin
            rst[d] = 1'b1;
            if (c + k < m_done[d]) begin
              m_busy_to[d] = c + k;
              m_done[d]    = -1;
            end
            m_rst[d] = c + k;
          end
          default: start[d] = 1'b1;
        endcase
      end
    end
    if (has_lit) begin
      got = d ? res1 : {32'b0, res0};
      chk(nm, got, lit);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; flush[d] = 1'b0;
      opc[d] = '0; opa[d] = '0; opb[d] = '0;
      m_active[d] = 1'b0; m_start[d] = -10; m_done[d] = -10;
      m_busy_to[d] = -10; m_rst[d] = -10; m_res[d] = '0; m_held[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    cmp_en = 1'b1;

    chk("reset_busy",   {63'b0, busy[0]}, 64'd0);
    chk("reset_done",   {63'b0, done[0]}, 64'd0);
    chk("reset_result", {32'b0, res0},    64'd0);

    // Pin the model to hand-computed values
    chk("model_mul",    model(32, MUL,    64'd7, 64'hFFFF_FFFD), 64'hFFFF_FFEB);
    chk("model_mulhsu", model(32, MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF), 64'hFFFF_FFFF);
    chk("model_div",    model(32, DIV,    64'hFFFF_FFF9, 64'd2), 64'hFFFF_FFFD);
    chk("model_rem",    model(32, REM,    64'hFFFF_FFF9, 64'd2), 64'hFFFF_FFFF);
    chk("model_mulhu64", model(64, MULHU, 64'h8000_0000_0000_0000, 64'd4), 64'd2);

    issue(0, MUL,    64'd7, 64'hFFFF_FFFD, 0, 0, 1, 64'hFFFF_FFEB, "mul_7x-3");
    issue(0, MULH,   64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, 1, 64'h0, "mulh_ones");
    issue(0, MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, 1, 64'hFFFF_FFFF, "mulhsu_ones");
    issue(0, MULHU,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, 1, 64'hFFFF_FFFE, "mulhu_ones");
    issue(0, DIV,    64'hFFFF_FFF9, 64'd2, 0, 0, 1, 64'hFFFF_FFFD, "div_-7_2");
    issue(0, REM,    64'hFFFF_FFF9, 64'd2, 0, 0, 1, 64'hFFFF_FFFF, "rem_-7_2");
    issue(0, DIVU,   64'd100, 64'd7, 0, 0, 1, 64'd14, "divu_100_7");
    issue(0, REMU,   64'd100, 64'd7, 0, 0, 1, 64'd2, "remu_100_7");
    issue(0, DIVU,   64'd5, 64'd0, 0, 0, 1, 64'hFFFF_FFFF, "divu_by_zero");
    issue(0, REM,    64'd5, 64'd0, 0, 0, 1, 64'd5, "rem_by_zero");
    issue(0, DIV,    64'h8000_0000, 64'hFFFF_FFFF, 0, 0, 1, 64'h8000_0000, "div_overflow");
    issue(0, MUL,    64'd123, 64'd456, 1, 10, 1, 64'h8000_0000, "flush_keeps_result");

    // Start together with Flush in IDLE must be dropped
    start[0] = 1'b1; flush[0] = 1'b1; opc[0] = MUL; opa[0] = 64'd3; opb[0] = 64'd3;
    @(posedge clk);
    #1;
    start[0] = 1'b0; flush[0] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("start_flush_idle_busy", {63'b0, busy[0]}, 64'd0);

    issue(0, MULHU, 64'hFFFF_FFFF, 64'h10, 3, 5, 1, 64'hF, "busy_start_ignored");
    issue(0, DIV,   64'd1000, 64'd3, 2, 20, 1, 64'd0, "reset_clears");

    issue(1, MULHU, 64'h8000_0000_0000_0000, 64'd4, 0, 0, 1, 64'd2, "mulhu64");
    issue(1, DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1,
          64'h8000_0000_0000_0000, "div64_overflow");

    for (int i = 0; i < 40; i++) begin
      int d, w, lat, kind, rel, r;
      logic [2:0] op;
      logic [63:0] a, b;
      d    = (i % 5 == 4) ? 1 : 0;
      w    = d ? 64 : 32;
      op   = 3'($urandom);
      a    = rnd(w);
      b    = rnd(w);
      lat  = is_special(w, op, a, b) ? 2 : w + 3;
      kind = 0;
      rel  = $urandom_range(1, lat);
      r    = $urandom_range(0, 9);
      if (r == 0) kind = 1;
      else if (r == 1) kind = 3;
      issue(d, op, a, b, kind, rel, 1'b0, 64'd0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
